// File: rtl/v4_peak_detector.sv
// -----------------------------------------------------------------------------
// package_settings / v4_peak_detector
//
// Purpose: detects pulses in the shaped output of a trapezoidal filter. Each
// pulse that rises above THRESHOLD produces one event: the peak amplitude,
// the timestamp of the peak sample, the time spent above threshold and a
// pileup flag. Events wait in a single output slot with a valid/ready
// handshake. Events that find the slot occupied are dropped and counted.
// After each event the detector ignores its input for a dead time.
//
// Ports:
//   clk            single clock
//   reset          asynchronous active-low reset
//   filt_data      signed filter sample, one per clk
//   evt_ready      consumer accepts the pending event
//   evt_valid      output slot holds an unconsumed event
//   evt_amplitude  peak value of the pulse
//   evt_time       timestamp of the peak sample
//   evt_width      samples above threshold, saturating at 255
//   evt_pileup     width exceeded MAX_WIDTH
//   lost_count     events dropped on a full slot, saturating
//   busy           detector is not idle
// -----------------------------------------------------------------------------
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

module v4_peak_detector
  import package_settings::*;
#(
  parameter logic signed [SIZE_FILTER_DATA-1:0] THRESHOLD = 100,
  parameter int HOLDOFF   = 16,
  parameter int MAX_WIDTH = 64,
  parameter int TS_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filt_data,
  input  logic                               evt_ready,
  output logic                               evt_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] evt_amplitude,
  output logic [TS_WIDTH-1:0]                evt_time,
  output logic [7:0]                         evt_width,
  output logic                               evt_pileup,
  output logic [15:0]                        lost_count,
  output logic                               busy
);

  // A zero dead time still spends one cycle in HOLD.
  localparam int          HOLD_LEN  = (HOLDOFF == 0) ? 1 : HOLDOFF;
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_FINISH, S_HOLD} state_t;

  state_t r_state;
  state_t w_state_next;

  // Input stage: each sample is registered together with the timestamp of
  // the edge that captured it, so the FSM sees sample and ts as a pair.
  logic signed [SIZE_FILTER_DATA-1:0] r_filt;
  logic [TS_WIDTH-1:0]                r_filt_ts;
  logic [TS_WIDTH-1:0]                r_ts;

  logic signed [SIZE_FILTER_DATA-1:0] r_peak;
  logic [TS_WIDTH-1:0]                r_peak_ts;
  logic [7:0]                         r_width;
  logic [31:0]                        r_hold_cnt;

  logic                               r_evt_valid;
  logic signed [SIZE_FILTER_DATA-1:0] r_evt_amplitude;
  logic [TS_WIDTH-1:0]                r_evt_time;
  logic [7:0]                         r_evt_width;
  logic                               r_evt_pileup;
  logic [15:0]                        r_lost_count;

  logic w_above;
  logic w_higher;
  logic w_hold_done;
  logic w_slot_free;
  logic w_load;
  logic w_drop;
  logic w_xfer;
  logic w_pileup;

  assign w_above     = (r_filt > THRESHOLD);
  assign w_higher    = (r_filt > r_peak);     // strict: ties keep earliest ts
  assign w_hold_done = (r_hold_cnt == HOLD_LAST);
  assign w_pileup    = (int'({24'd0, r_width}) > MAX_WIDTH);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_above)     w_state_next = S_RISE;
      S_RISE:   if (!w_above)    w_state_next = S_FINISH;
      S_FINISH:                  w_state_next = S_HOLD;
      S_HOLD:   if (w_hold_done) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_slot_free = !r_evt_valid || evt_ready;
    w_load      = (r_state == S_FINISH) && w_slot_free;
    w_drop      = (r_state == S_FINISH) && !w_slot_free;
    w_xfer      = r_evt_valid && evt_ready;
    busy        = (r_state != S_IDLE);
  end

  // Datapath and output slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts            <= '0;
      r_filt          <= '0;
      r_filt_ts       <= '0;
      r_peak          <= '0;
      r_peak_ts       <= '0;
      r_width         <= '0;
      r_hold_cnt      <= '0;
      r_evt_valid     <= 1'b0;
      r_evt_amplitude <= '0;
      r_evt_time      <= '0;
      r_evt_width     <= '0;
      r_evt_pileup    <= 1'b0;
      r_lost_count    <= '0;
    end else begin
      r_ts      <= r_ts + 1'b1;
      r_filt    <= filt_data;
      r_filt_ts <= r_ts;

      unique case (r_state)
        S_IDLE: begin
          if (w_above) begin
            r_peak    <= r_filt;
            r_peak_ts <= r_filt_ts;
            r_width   <= 8'd1;
          end
        end
        S_RISE: begin
          if (w_above) begin
            if (r_width != 8'hFF) r_width <= r_width + 8'd1;
            if (w_higher) begin
              r_peak    <= r_filt;
              r_peak_ts <= r_filt_ts;
            end
          end
        end
        S_FINISH: begin
          r_hold_cnt <= '0;
        end
        S_HOLD: begin
          r_hold_cnt <= w_hold_done ? 32'd0 : r_hold_cnt + 32'd1;
        end
        default: ;
      endcase

      // A load in the same cycle as a transfer keeps valid high with new data.
      if (w_load) begin
        r_evt_valid     <= 1'b1;
        r_evt_amplitude <= r_peak;
        r_evt_time      <= r_peak_ts;
        r_evt_width     <= r_width;
        r_evt_pileup    <= w_pileup;
      end else if (w_xfer) begin
        r_evt_valid <= 1'b0;
      end

      if (w_drop && (r_lost_count != 16'hFFFF)) begin
        r_lost_count <= r_lost_count + 16'd1;
      end
    end
  end

  assign evt_valid     = r_evt_valid;
  assign evt_amplitude = r_evt_amplitude;
  assign evt_time      = r_evt_time;
  assign evt_width     = r_evt_width;
  assign evt_pileup    = r_evt_pileup;
  assign lost_count    = r_lost_count;

endmodule

// File: tb/tb_v4_peak_detector.sv
module tb_v4_peak_detector;
  import package_settings::*;

  localparam int TH    = 100;
  localparam int HOLD  = 16;
  localparam int MAXW  = 64;
  localparam int HLEN  = (HOLD == 0) ? 1 : HOLD;
  localparam int NMAX  = 512;

  logic                               clk = 1'b0;
  logic                               reset = 1'b0;
  logic signed [SIZE_FILTER_DATA-1:0] filt_data = '0;
  logic                               evt_ready = 1'b0;
  logic                               evt_valid;
  logic signed [SIZE_FILTER_DATA-1:0] evt_amplitude;
  logic [31:0]                        evt_time;
  logic [7:0]                         evt_width;
  logic                               evt_pileup;
  logic [15:0]                        lost_count;
  logic                               busy;

  v4_peak_detector #(.THRESHOLD(16'sd100), .HOLDOFF(HOLD), .MAX_WIDTH(MAXW), .TS_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .filt_data(filt_data), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_amplitude(evt_amplitude), .evt_time(evt_time),
    .evt_width(evt_width), .evt_pileup(evt_pileup), .lost_count(lost_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus for one segment
  int samp [NMAX];
  bit rdy  [NMAX];

  // offline reference: event offered to the slot at a given edge
  bit off_v   [NMAX];
  int off_amp [NMAX];
  int off_time[NMAX];
  int off_w   [NMAX];
  bit off_p   [NMAX];
  bit busy_m  [NMAX];

  // slot model
  bit m_v; int m_amp, m_time, m_w; bit m_p; int m_lost;

  // observations for literal checks
  int cap_amp, cap_time, cap_w, cap_p, cap_edge, valid_edges, busy_edges;
  int hist_amp[NMAX];
  bit hist_v  [NMAX];

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scan the whole sample stream for pulses, honouring the dead time.
  // Sample k is seen by the detector on edge k+1; a pulse ending at sample j
  // is offered on edge j+2 and the detector listens again from sample j+2+HLEN.
  function automatic void build_model(input int n);
    int i, j, pk, peak, w;
    for (int k = 0; k < NMAX; k++) begin
      off_v[k] = 0; off_amp[k] = 0; off_time[k] = 0; off_w[k] = 0; off_p[k] = 0; busy_m[k] = 0;
    end
    i = 0;
    while (i < n) begin
      if (samp[i] > TH) begin
        j = i + 1;
        while (j < n && samp[j] > TH) j++;
        if (j >= n) break;
        peak = samp[i]; pk = i;
        for (int m = i; m < j; m++) if (samp[m] > peak) begin peak = samp[m]; pk = m; end
        w = (j - i > 255) ? 255 : j - i;
        if (j + 2 < n) begin
          off_v[j+2] = 1; off_amp[j+2] = peak; off_time[j+2] = pk;
          off_w[j+2] = w; off_p[j+2] = (w > MAXW);
        end
        for (int b = i + 1; b <= j + 1 + HLEN; b++) if (b < n) busy_m[b] = 1;
        i = j + 2 + HLEN;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic do_reset();
    reset = 1'b0; filt_data = '0; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Compare the DUT with the model after edge k.
  task automatic check_edge(input int k);
    if (off_v[k]) begin
      if (!m_v || rdy[k]) begin
        m_v = 1; m_amp = off_amp[k]; m_time = off_time[k]; m_w = off_w[k]; m_p = off_p[k];
      end else if (m_lost < 65535) m_lost++;
    end else if (m_v && rdy[k]) m_v = 0;
    chk($sformatf("valid@%0d", k), evt_valid, m_v);
    chk($sformatf("lost@%0d", k), lost_count, m_lost);
    chk($sformatf("busy@%0d", k), busy, busy_m[k]);
    if (m_v && evt_valid) begin
      chk($sformatf("amp@%0d", k), $signed(evt_amplitude), m_amp);
      chk($sformatf("time@%0d", k), evt_time, m_time);
      chk($sformatf("width@%0d", k), evt_width, m_w);
      chk($sformatf("pileup@%0d", k), evt_pileup, m_p);
    end
    hist_amp[k] = $signed(evt_amplitude);
    hist_v[k]   = evt_valid;
    if (evt_valid) begin
      if (cap_edge < 0) begin
        cap_edge = k; cap_amp = $signed(evt_amplitude); cap_time = int'(evt_time);
        cap_w = int'(evt_width); cap_p = int'(evt_pileup);
      end
      valid_edges++;
    end
    if (busy) busy_edges++;
  endtask

  task automatic run_segment(input string name, input int n);
    build_model(n);
    m_v = 0; m_amp = 0; m_time = 0; m_w = 0; m_p = 0; m_lost = 0;
    cap_edge = -1; cap_amp = 0; cap_time = 0; cap_w = 0; cap_p = 0;
    valid_edges = 0; busy_edges = 0;
    do_reset();
    #1;
    chk({name, ":rst_valid"}, evt_valid, 0);
    chk({name, ":rst_busy"}, busy, 0);
    chk({name, ":rst_lost"}, lost_count, 0);
    for (int k = 0; k < n; k++) begin
      filt_data = 16'(samp[k]);
      evt_ready = rdy[k];
      @(posedge clk);
      #1;
      check_edge(k);
    end
    $display("[TB] segment %s: %0d edges, %0d valid edges, lost %0d", name, n, valid_edges, lost_count);
  endtask

  task automatic clear_stim(input bit r);
    for (int k = 0; k < NMAX; k++) begin samp[k] = 0; rdy[k] = r; end
  endtask

  initial begin
    // single pulse
    clear_stim(1);
    samp[1] = 50; samp[2] = 150; samp[3] = 300; samp[4] = 200; samp[5] = 90;
    run_segment("single", 40);
    chk("single:amp", cap_amp, 300);
    chk("single:time", cap_time, 3);
    chk("single:width", cap_w, 3);
    chk("single:pileup", cap_p, 0);
    chk("single:rise_edge", cap_edge, 7);
    chk("single:valid_cycles", valid_edges, 1);

    // backpressure: second event is dropped, first one is held
    clear_stim(0);
    samp[2] = 150; samp[3] = 300; samp[4] = 150;
    samp[42] = 200; samp[43] = 500; samp[44] = 200;
    rdy[100] = 1;
    run_segment("backpressure", 120);
    chk("bp:amp_held", hist_amp[99], 300);
    chk("bp:valid_held", hist_v[99], 1);
    chk("bp:lost", lost_count, 1);
    chk("bp:valid_after_ready", hist_v[100], 0);

    // pileup
    clear_stim(1);
    for (int k = 2; k < 72; k++) samp[k] = 200;
    run_segment("pileup", 120);
    chk("pile:width", cap_w, 70);
    chk("pile:pileup", cap_p, 1);
    chk("pile:amp", cap_amp, 200);
    chk("pile:time", cap_time, 2);

    // width saturation
    clear_stim(1);
    for (int k = 2; k < 302; k++) samp[k] = 200;
    run_segment("saturate", 360);
    chk("sat:width", cap_w, 255);
    chk("sat:pileup", cap_p, 1);

    // holdoff: second pulse inside the dead time is ignored
    clear_stim(1);
    samp[2] = 150; samp[3] = 300; samp[4] = 150;
    for (int k = 11; k < 14; k++) samp[k] = 250;
    run_segment("holdoff", 80);
    chk("hold:events", valid_edges, 1);
    chk("hold:lost", lost_count, 0);

    // negative and boundary input never trigger
    clear_stim(1);
    for (int k = 0; k < 20; k++) samp[k] = -200;
    for (int k = 20; k < 40; k++) samp[k] = 100;
    for (int k = 40; k < 50; k++) samp[k] = -32768;
    run_segment("boundary", 60);
    chk("bnd:busy_edges", busy_edges, 0);
    chk("bnd:events", valid_edges, 0);

    // randomized segments
    for (int s = 0; s < 8; s++) begin
      int plen, ramp;
      plen = 0;
      for (int k = 0; k < 400; k++) begin
        if (plen == 0 && $urandom_range(0, 19) == 0) plen = $urandom_range(1, 80);
        if (plen > 0) begin
          ramp = (s < 4) ? 300 : 2000;
          samp[k] = $urandom_range(101, 101 + ramp);
          plen--;
        end else begin
          samp[k] = int'($urandom_range(0, 400)) - 300;
        end
        if (k >= 360) samp[k] = 0;
        rdy[k] = (s % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      end
      run_segment($sformatf("rand%0d", s), 400);
    end

    // reset in the middle of a pulse
    do_reset();
    begin
      int pre [6] = '{0, 0, 150, 250, 200, 200};
      for (int k = 0; k < 6; k++) begin
        filt_data = 16'(pre[k]); evt_ready = 1'b1;
        @(posedge clk);
      end
      #1;
      chk("rstmid:busy_before", busy, 1);
      reset = 1'b0;
      #1;
      for (int c = 0; c < 2; c++) begin
        chk("rstmid:valid", evt_valid, 0);
        chk("rstmid:amp", evt_amplitude, 0);
        chk("rstmid:time", evt_time, 0);
        chk("rstmid:width", evt_width, 0);
        chk("rstmid:pileup", evt_pileup, 0);
        chk("rstmid:lost", lost_count, 0);
        chk("rstmid:busy", busy, 0);
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      reset = 1'b1;
      filt_data = '0;
      valid_edges = 0; busy_edges = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (evt_valid) valid_edges++;
        if (busy) busy_edges++;
      end
      chk("rstmid:events_after", valid_edges, 0);
      chk("rstmid:busy_after", busy_edges, 0);
      chk("rstmid:lost_after", lost_count, 0);
      $display("[TB] segment reset_mid: events after release %0d", valid_edges);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/v4_peak_detector.md
V4_PEAK_DETECTOR -- requirements
Module: v4_peak_detector

Interface
REQ-001 The block SHALL take parameter THRESHOLD, default 100: signed trigger level, same width as the filter output.
REQ-002 The block SHALL take parameter HOLDOFF, default 16: dead-time cycles after each event.
REQ-003 The block SHALL take parameter MAX_WIDTH, default 64: pulse width above which an event is flagged as pileup.
REQ-004 The block SHALL take parameter TS_WIDTH, default 32: timestamp width.
REQ-005 The block SHALL take SIZE_FILTER_DATA from package_settings.
REQ-006 clk  input  1  single clock; every signal is in this domain.
REQ-007 reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
REQ-008 filt_data  input  signed SIZE_FILTER_DATA  shaped sample from the trapezoidal filter, one sample per clk.
REQ-009 evt_ready  input  1  consumer accepts the event.
REQ-010 evt_valid  output  1  event registers hold an unconsumed event.
REQ-011 evt_amplitude  output  signed SIZE_FILTER_DATA  peak value of the pulse.
REQ-012 evt_time  output  TS_WIDTH  timestamp of the peak sample.
REQ-013 evt_width  output  8  cycles above threshold, saturating at 255.
REQ-014 evt_pileup  output  1  width exceeded MAX_WIDTH.
REQ-015 lost_count  output  16  events dropped because the output slot was full, saturating.
REQ-016 busy  output  1  state is not IDLE.

Function
REQ-017 The block SHALL run a free-running timestamp counter ts that increments every clk and wraps from 2^TS_WIDTH-1 to 0.
REQ-018 The block SHALL use states IDLE, RISE, FINISH and HOLD.
REQ-019 In IDLE, if filt_data > THRESHOLD (signed, strict), the block SHALL go to RISE, set peak=filt_data, peak_ts=ts and width=1.
REQ-020 In RISE, while filt_data > THRESHOLD, the block SHALL increment width (saturating at 255); if filt_data > peak (strict), it SHALL update peak and peak_ts.
REQ-021 Equal samples SHALL keep the earliest timestamp.
REQ-022 In RISE, if filt_data <= THRESHOLD, the block SHALL go to FINISH; that sample SHALL NOT count toward width.
REQ-023 In FINISH, the slot is free when evt_valid=0 or evt_ready=1. If free, the block SHALL load evt_amplitude=peak, evt_time=peak_ts, evt_width=width, evt_pileup=(width>MAX_WIDTH) and set evt_valid=1. If not free, it SHALL drop the event and increment lost_count, saturating at 65535.
REQ-024 FINISH SHALL always go to HOLD.
REQ-025 In HOLD, the block SHALL count HOLDOFF cycles with input ignored, then return to IDLE.
REQ-026 With HOLDOFF=0, HOLD SHALL last 1 cycle.
REQ-027 Latency: evt_valid SHALL rise on the 2nd rising edge after the edge that samples the first filt_data <= THRESHOLD.
REQ-028 Handshake: the event transfers on a clk edge where evt_valid=1 and evt_ready=1.
REQ-029 evt_valid and all evt_* outputs SHALL remain stable until transfer.
REQ-030 evt_valid SHALL clear after transfer unless FINISH loads a new event in the same cycle; in that case evt_valid stays 1 with the new data.
REQ-031 evt_ready while evt_valid=0 SHALL have no effect.
REQ-032 All comparisons SHALL be signed; negative samples never trigger.

Reset
REQ-033 While reset=0, the block SHALL asynchronously force state=IDLE and clear ts, peak, peak_ts, width, the holdoff counter, evt_valid, evt_amplitude, evt_time, evt_width, evt_pileup, lost_count and busy to 0.
REQ-034 An in-progress pulse SHALL be discarded by reset and produce no event after release.
REQ-035 After reset release, the first clk edge SHALL sample normally with ts=0.

Verification
REQ-036 Single pulse: reset, then evt_ready=1 and filt_data 0,50,150,300,200,90,0 on cycles 0-6 -> one event: amplitude 300, time 3, width 3, pileup 0; evt_valid high for 1 cycle, rising on the 2nd edge after the sample 90.
REQ-037 Backpressure: evt_ready=0 and two pulses (peaks 300, then 500), 40 cycles apart -> evt_amplitude stays 300, lost_count=1; after evt_ready=1 for one cycle, evt_valid=0.
REQ-038 Pileup: filt_data=200 for 70 cycles, then 0 -> width 70, pileup 1, amplitude 200, time equal to the first 200 sample.
REQ-039 Holdoff: a second pulse crossing THRESHOLD 5 cycles after FINISH -> ignored, no second event, lost_count unchanged.
REQ-040 Reset mid-operation: reset=0 for 2 cycles during RISE (peak 250) -> all outputs 0 during reset, busy 0, no event after release.
REQ-041 Negative and boundary input: filt_data=-200 and filt_data=100 (equal to THRESHOLD) -> busy stays 0, no event.
